alu_op_sequencer: RTL and testbench

// - Multi-cycle control stage directly upstream of the 32-bit ALU: accepts one operation per valid/ready handshake,

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_flag_reg.sv | 28 ++
 rtl/alu_op_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcodes, sequencer state encoding and opcode classification shared by the ALU and its control stage.
package alu_pkg;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'b010000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b010001;
   localparam logic [OP_W-1:0] OP_EQ  = 6'b100000;
   localparam logic [OP_W-1:0] OP_NE  = 6'b100001;
   localparam logic [OP_W-1:0] OP_LE  = 6'b100010;
   localparam logic [OP_W-1:0] OP_GT  = 6'b100011;
   localparam logic [OP_W-1:0] OP_LLS = 6'b110000;
   localparam logic [OP_W-1:0] OP_LRS = 6'b110001;
   localparam logic [OP_W-1:0] OP_ARS = 6'b110010;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
         OP_LLS, OP_LRS, OP_ARS: is_legal_op = 1'b1;
         default:                is_legal_op = 1'b0;
      endcase
   endfunction

   function automatic logic is_shift_op(input logic [OP_W-1:0] op);
      is_shift_op = (op == OP_LLS) || (op == OP_LRS) || (op == OP_ARS);
   endfunction

   function automatic logic is_arith_op(input logic [OP_W-1:0] op);
      is_arith_op = (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural C/Z/N flag registers, each with its own load enable; new value visible the cycle after load.
module alu_flag_reg (
   input  logic clk,
   input  logic rst,
   input  logic ld_c,
   input  logic ld_z,
   input  logic ld_n,
   input  logic c_d,
   input  logic z_d,
   input  logic n_d,
   output logic flag_c,
   output logic flag_z,
   output logic flag_n
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_c <= 1'b0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else begin
         if (ld_c) flag_c <= c_d;
         if (ld_z) flag_z <= z_d;
         if (ld_n) flag_n <= n_d;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control stage in front of a combinational ALU: one op per 4 cycles, result 3 edges after accept (2 if illegal).
// Holds the result in WB until res_ready; instr_ready stays low from accept until the result is taken.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [OP_W-1:0]  instr_op,
   input  logic [DW-1:0]    instr_a,
   input  logic [DW-1:0]    instr_b,
   input  logic             instr_use_c,
   output logic [DW-1:0]    alu_a,
   output logic [DW-1:0]    alu_b,
   output logic [OP_W-1:0]  alu_op,
   output logic             alu_cin,
   input  logic [DW-1:0]    alu_res,
   input  logic             alu_cout,
   input  logic             alu_z,
   input  logic             alu_n,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DW-1:0]    res_data,
   output logic             res_illegal,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic [CNT_W-1:0] op_count
);

   state_t          state;
   logic [OP_W-1:0] op_q;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic            use_c_q;
   logic            ld_zn;
   logic            ld_c;

   // Flags commit at the end of EXEC, together with res_data; carry only moves on ADD/SUB.
   assign ld_zn = (state == ST_EXEC);
   assign ld_c  = ld_zn && is_arith_op(alu_op);

   alu_flag_reg u_flags (
      .clk    (clk),
      .rst    (rst),
      .ld_c   (ld_c),
      .ld_z   (ld_zn),
      .ld_n   (ld_zn),
      .c_d    (alu_cout),
      .z_d    (alu_z),
      .n_d    (alu_n),
      .flag_c (flag_c),
      .flag_z (flag_z),
      .flag_n (flag_n)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         instr_ready <= 1'b1;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         use_c_q     <= 1'b0;
         alu_a       <= '0;
         alu_b       <= '0;
         alu_op      <= '0;
         alu_cin     <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_illegal <= 1'b0;
         op_count    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (instr_valid) begin
                  op_q        <= instr_op;
                  a_q         <= instr_a;
                  b_q         <= instr_b;
                  use_c_q     <= instr_use_c;
                  instr_ready <= 1'b0;
                  state       <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (is_legal_op(op_q)) begin
                  alu_a   <= a_q;
                  // Shift amount is taken mod 32 so the ALU never sees an oversized shift.
                  alu_b   <= is_shift_op(op_q) ? {{(DW-5){1'b0}}, b_q[4:0]} : b_q;
                  alu_op  <= op_q;
                  alu_cin <= use_c_q & flag_c;
                  state   <= ST_EXEC;
               end else begin
                  res_data    <= '0;
                  res_illegal <= 1'b1;
                  res_valid   <= 1'b1;
                  state       <= ST_WB;
               end
            end
            ST_EXEC: begin
               res_data    <= alu_res;
               res_illegal <= 1'b0;
               res_valid   <= 1'b1;
               op_count    <= op_count + 1'b1;
               state       <= ST_WB;
            end
            ST_WB: begin
               if (res_ready) begin
                  res_valid   <= 1'b0;
                  instr_ready <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 32-bit ALU attached to its alu_* lines.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   localparam int DW    = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             instr_valid;
   logic             instr_ready;
   logic [5:0]       instr_op;
   logic [DW-1:0]    instr_a;
   logic [DW-1:0]    instr_b;
   logic             instr_use_c;
   logic [DW-1:0]    alu_a;
   logic [DW-1:0]    alu_b;
   logic [5:0]       alu_op;
   logic             alu_cin;
   logic [DW-1:0]    alu_res;
   logic             alu_cout;
   logic             alu_z;
   logic             alu_n;
   logic             res_valid;
   logic             res_ready;
   logic [DW-1:0]    res_data;
   logic             res_illegal;
   logic             flag_c;
   logic             flag_z;
   logic             flag_n;
   logic [CNT_W-1:0] op_count;

   int n_chk  = 0;
   int n_pass = 0;
   logic [CNT_W-1:0] exp_cnt;

   always #5 clk = ~clk;

   alu_op_sequencer #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_a(instr_a), .instr_b(instr_b), .instr_use_c(instr_use_c),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
      .alu_res(alu_res), .alu_cout(alu_cout), .alu_z(alu_z), .alu_n(alu_n),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_illegal(res_illegal),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .op_count(op_count)
   );

   // Combinational ALU: SUB carry-out is the borrow.
   logic [DW:0] wide;
   always_comb begin
      wide = '0;
      case (alu_op)
         OP_ADD: wide = {1'b0, alu_a} + {1'b0, alu_b} + {{DW{1'b0}}, alu_cin};
         OP_SUB: wide = {1'b0, alu_a} - {1'b0, alu_b} - {{DW{1'b0}}, alu_cin};
         OP_EQ:  wide = {{DW{1'b0}}, alu_a == alu_b};
         OP_NE:  wide = {{DW{1'b0}}, alu_a != alu_b};
         OP_LE:  wide = {{DW{1'b0}}, $signed(alu_a) <= $signed(alu_b)};
         OP_GT:  wide = {{DW{1'b0}}, $signed(alu_a) > $signed(alu_b)};
         OP_LLS: wide = {1'b0, alu_a << alu_b[4:0]};
         OP_LRS: wide = {1'b0, alu_a >> alu_b[4:0]};
         OP_ARS: wide = {1'b0, $unsigned($signed(alu_a) >>> alu_b[4:0])};
         default: wide = '0;
      endcase
      alu_res  = wide[DW-1:0];
      alu_cout = wide[DW];
      alu_z    = (wide[DW-1:0] == '0);
      alu_n    = wide[DW-1];
   end

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        use_c;
      logic [31:0] res;
      logic        ill;
      logic        c;
      logic        z;
      logic        n;
      logic [31:0] ab;
      logic        cin;
      int          lat;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic offer(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input logic uc);
      @(negedge clk);
      chk("instr_ready_before_accept", {31'b0, instr_ready}, 32'd1);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_a     = a;
      instr_b     = b;
      instr_use_c = uc;
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   // Counts negedges after the accepting edge until res_valid is seen; 9 means it never came.
   task automatic wait_res(output int cyc);
      cyc = 9;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (res_valid) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic release_res();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      chk("res_valid_after_take", {31'b0, res_valid}, 32'd0);
      chk("instr_ready_after_take", {31'b0, instr_ready}, 32'd1);
   endtask

   task automatic do_op(input vec_t v, input string tag);
      int cyc;
      offer(v.op, v.a, v.b, v.use_c);
      wait_res(cyc);
      if (!v.ill) exp_cnt = exp_cnt + 1'b1;
      chk({tag, "_latency"}, cyc, v.lat);
      chk({tag, "_res_data"}, res_data, v.res);
      chk({tag, "_res_illegal"}, {31'b0, res_illegal}, {31'b0, v.ill});
      chk({tag, "_flag_c"}, {31'b0, flag_c}, {31'b0, v.c});
      chk({tag, "_flag_z"}, {31'b0, flag_z}, {31'b0, v.z});
      chk({tag, "_flag_n"}, {31'b0, flag_n}, {31'b0, v.n});
      chk({tag, "_alu_b"}, alu_b, v.ab);
      chk({tag, "_alu_cin"}, {31'b0, alu_cin}, {31'b0, v.cin});
      chk({tag, "_op_count"}, {28'b0, op_count}, {28'b0, exp_cnt});
      chk({tag, "_instr_ready_in_wb"}, {31'b0, instr_ready}, 32'd0);
      release_res();
   endtask

   initial begin
      int cyc;
      int seen;
      vec_t z;

      tbl[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h1,  1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 3};
      tbl[1]  = '{6'b111111, 32'h5,     32'h7,  1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 2};
      tbl[2]  = '{OP_LLS, 32'h1,        32'd33, 1'b0, 32'h2,        1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 3};
      tbl[3]  = '{OP_EQ,  32'h5,        32'h5,  1'b0, 32'h1,        1'b0, 1'b1, 1'b0, 1'b0, 32'h5, 1'b0, 3};
      tbl[4]  = '{OP_ADD, 32'h1,        32'h1,  1'b1, 32'h3,        1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 1'b1, 3};
      tbl[5]  = '{OP_SUB, 32'h0,        32'h1,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1, 1'b0, 3};
      tbl[6]  = '{OP_SUB, 32'h5,        32'h3,  1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 32'h3, 1'b1, 3};
      tbl[7]  = '{OP_NE,  32'h4,        32'h4,  1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 1'b0, 3};
      tbl[8]  = '{OP_ARS, 32'h80000000, 32'h4,  1'b0, 32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4, 1'b0, 3};
      tbl[9]  = '{OP_LRS, 32'h80000000, 32'h24, 1'b0, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 3};
      tbl[10] = '{OP_GT,  32'h7,        32'h3,  1'b0, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0, 32'h3, 1'b0, 3};
      tbl[11] = '{6'b000000, 32'h1,     32'h2,  1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h3, 1'b0, 2};

      rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_a = '0; instr_b = '0;
      instr_use_c = 1'b0; res_ready = 1'b0; exp_cnt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
      chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_flags", {29'b0, flag_c, flag_z, flag_n}, 32'd0);
      chk("rst_op_count", {28'b0, op_count}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) do_op(tbl[i], $sformatf("vec%0d", i));

      // Backpressure: result and flow control must hold while downstream stalls.
      offer(OP_ADD, 32'h2, 32'h3, 1'b0);
      wait_res(cyc);
      exp_cnt = exp_cnt + 1'b1;
      chk("bp_latency", cyc, 3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
         chk("bp_res_data", res_data, 32'd5);
         chk("bp_instr_ready", {31'b0, instr_ready}, 32'd0);
      end
      release_res();
      z = '{OP_ADD, 32'h10, 32'h20, 1'b0, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b0, 3};
      do_op(z, "after_bp");

      // Reset while the operation is in EXEC.
      offer(OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("exec_rst_instr_ready", {31'b0, instr_ready}, 32'd1);
      chk("exec_rst_res_valid", {31'b0, res_valid}, 32'd0);
      chk("exec_rst_alu_a", alu_a, 32'd0);
      chk("exec_rst_alu_b", alu_b, 32'd0);
      chk("exec_rst_alu_op_cin", {25'b0, alu_op, alu_cin}, 32'd0);
      chk("exec_rst_res", {res_illegal, res_data[30:0]}, 32'd0);
      chk("exec_rst_flags", {29'b0, flag_c, flag_z, flag_n}, 32'd0);
      chk("exec_rst_op_count", {28'b0, op_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = '0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      chk("exec_rst_no_result", seen, 0);

      // 16 legal ops wrap the 4-bit counter back to zero.
      z = '{OP_ADD, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 3};
      for (int i = 0; i < 16; i++) do_op(z, $sformatf("wrap%0d", i));
      chk("wrap_op_count", {28'b0, op_count}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
